// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU with NZCV flags, branch target adder, and an
// iterative radix-2 shift-add multiplier behind a valid/ready handshake.
module exe_stage_mc #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 24,
    parameter int unsigned MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        EXE_CMD,
    input  logic [DATA_W-1:0] Val_Rn,
    input  logic [DATA_W-1:0] Val2,
    input  logic [DATA_W-1:0] PC,
    input  logic [IMM_W-1:0]  Signed_imm,
    input  logic [3:0]        SR,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] Br_addr,
    output logic [3:0]        status,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned MSB   = DATA_W - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    logic [0:0]        state_q,     state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic [DATA_W-1:0] br_q,        br_d;
    logic [3:0]        status_q,    status_d;
    logic [DATA_W-1:0] mcand_q,     mcand_d;
    logic [DATA_W-1:0] mplier_q,    mplier_d;
    logic [DATA_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [1:0]        cv_q,        cv_d;

    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_st;
    logic [DATA_W-1:0] b_eff;
    logic              cin;
    logic              is_arith;
    logic              use_sr;
    logic              ovf;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] br_c;
    logic [DATA_W-1:0] acc_step;
    logic              accept;
    logic              mul_start;

    // Subtraction is a + ~b + cin so C falls out as NOT borrow.
    always_comb begin
        alu_res  = Val_Rn;
        b_eff    = Val2;
        cin      = 1'b0;
        is_arith = 1'b0;
        use_sr   = 1'b0;
        case (EXE_CMD)
            CMD_MOV: alu_res = Val2;
            CMD_MVN: alu_res = ~Val2;
            CMD_ADD: is_arith = 1'b1;
            CMD_ADC: begin is_arith = 1'b1; cin = SR[1]; end
            CMD_SUB: begin is_arith = 1'b1; b_eff = ~Val2; cin = 1'b1; end
            CMD_SBC: begin is_arith = 1'b1; b_eff = ~Val2; cin = SR[1]; end
            CMD_AND: alu_res = Val_Rn & Val2;
            CMD_ORR: alu_res = Val_Rn | Val2;
            CMD_EOR: alu_res = Val_Rn ^ Val2;
            CMD_MUL: alu_res = Val2;
            default: use_sr = 1'b1;
        endcase
        sum = {1'b0, Val_Rn} + {1'b0, b_eff} + (DATA_W + 1)'(cin);
        ovf = (Val_Rn[MSB] == b_eff[MSB]) & (sum[MSB] != Val_Rn[MSB]);
        if (is_arith) begin
            alu_res = sum[DATA_W-1:0];
        end
        if (use_sr) begin
            alu_st = SR;
        end else begin
            alu_st = {alu_res[MSB], alu_res == '0,
                      is_arith ? sum[DATA_W] : SR[1],
                      is_arith ? ovf         : SR[0]};
        end
    end

    // Branch target: word offset scaled to bytes, wraps modulo 2^DATA_W.
    always_comb begin
        imm_ext = {{(DATA_W - IMM_W){Signed_imm[IMM_W-1]}}, Signed_imm};
        br_c    = PC + (imm_ext << 2);
    end

    assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready) & ~rst;
    assign accept    = in_valid & in_ready & ~flush;
    assign mul_start = accept & (EXE_CMD == CMD_MUL) & (MUL_EN != 0);
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        br_d        = br_q;
        status_d    = status_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cv_d        = cv_q;

        if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == S_IDLE) begin
            if (accept) begin
                br_d = br_c;
                if (mul_start) begin
                    state_d  = S_MUL;
                    mcand_d  = Val_Rn;
                    mplier_d = Val2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    cv_d     = SR[1:0];
                end else begin
                    result_d    = alu_res;
                    status_d    = alu_st;
                    out_valid_d = 1'b1;
                end
            end
        end else begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                state_d     = S_IDLE;
                result_d    = acc_step;
                status_d    = {acc_step[MSB], acc_step == '0, cv_q};
                out_valid_d = 1'b1;
            end
        end

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_q        <= '0;
            status_q    <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            cv_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            br_q        <= br_d;
            status_q    <= status_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cv_q        <= cv_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ALU_result = result_q;
    assign Br_addr    = br_q;
    assign status     = status_q;
    assign busy       = (state_q == S_MUL);

endmodule

// File: doc/exe_stage_mc.md
EXE_STAGE_MC -- requirements
Module: exe_stage_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width, allowed 8..64, even.
REQ-002 SHALL have parameter IMM_W, default 24: branch immediate width, allowed < DATA_W-2.
REQ-003 SHALL have parameter MUL_EN, default 1: 1 enables the iterative MUL command; 0 makes MUL behave as MOV.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port flush, input, 1: abandon the in-flight op and output.
REQ-007 SHALL have port in_valid, input, 1: request present.
REQ-008 SHALL have port in_ready, output, 1: request accepted when in_valid & in_ready.
REQ-009 SHALL have port EXE_CMD, input, 4: operation code.
REQ-010 SHALL have ports Val_Rn and Val2, input, DATA_W each: operand 1 and pre-generated operand 2.
REQ-011 SHALL have port PC, input, DATA_W: PC of the request.
REQ-012 SHALL have port Signed_imm, input, IMM_W: branch offset in words.
REQ-013 SHALL have port SR, input, 4: {N,Z,C,V}, sampled at accept.
REQ-014 SHALL have port out_valid, output, 1: result registers hold a valid result.
REQ-015 SHALL have port out_ready, input, 1: consumer takes the result when out_valid & out_ready.
REQ-016 SHALL have ports ALU_result and Br_addr, output, DATA_W each: registered result and branch target.
REQ-017 SHALL have port status, output, 4: registered {N,Z,C,V}.
REQ-018 SHALL have port busy, output, 1: high while the FSM is in MUL.

Function
REQ-019 SHALL decode EXE_CMD: 0001 MOV (Val2); 1001 MVN (~Val2); 0010 ADD; 0011 ADC (+C); 0100 SUB; 0101 SBC (-!C); 0110 AND; 0111 ORR; 1000 EOR; 1010 MUL (low DATA_W bits of Val_Rn*Val2); all others return Val_Rn with status = SR.
REQ-020 SHALL compute C for ADD/ADC as the carry out of bit DATA_W-1 and for SUB/SBC as NOT borrow; V as signed overflow; N = result MSB; Z = result==0.
REQ-021 SHALL pass SR C and V through unchanged for MOV, MVN, AND, ORR, EOR and MUL.
REQ-022 SHALL compute Br_addr = PC + (sign-extended Signed_imm << 2), modulo 2^DATA_W, registered at accept.
REQ-023 SHALL implement FSM IDLE/MUL; IDLE -> MUL on accepting MUL when MUL_EN=1; MUL -> IDLE after exactly DATA_W iterations.
REQ-024 SHALL drive in_ready = (state==IDLE) & (!out_valid | out_ready).
REQ-025 SHALL give non-MUL ops 1-cycle latency: accept at edge k, out_valid=1 with result after edge k.
REQ-026 SHALL run MUL as radix-2 shift-add, 1 bit per cycle; out_valid rises DATA_W cycles after accept.
REQ-027 SHALL hold ALU_result, Br_addr and status stable while out_valid & !out_ready.
REQ-028 SHALL clear out_valid on a consume unless a new result is written in the same cycle; back-to-back ALU ops SHALL sustain 1 op/cycle when out_ready=1.
REQ-029 SHALL, on flush, return to IDLE, clear out_valid, and ignore any in_valid in that cycle.

Reset
REQ-030 SHALL, on rst at a clk edge, set state IDLE, out_valid=0, busy=0, ALU_result=0, Br_addr=0, status=0.
REQ-031 SHALL give rst priority over flush and in_valid; rst mid-MUL SHALL discard the partial product with no out_valid pulse.
REQ-032 SHALL hold in_ready=0 while rst is high.

Verification
REQ-033 SHALL pass ADD with Val_Rn=0x7FFFFFFF, Val2=1 -> 1 cycle later ALU_result=0x80000000, status=1001 (N,V).
REQ-034 SHALL pass SUB with Val_Rn=5, Val2=5 -> ALU_result=0, status=0110 (Z,C).
REQ-035 SHALL pass MUL with Val_Rn=0xFFFF, Val2=0x10001 -> busy for 32 cycles, in_ready=0 throughout, then ALU_result=0xFFFFFFFF with N=1 and C,V taken from SR.
REQ-036 SHALL pass this branch case: PC=0x100, Signed_imm=0xFFFFFF -> Br_addr=0xFC.
REQ-037 SHALL pass this backpressure case: out_ready=0 with a result held, then ADD presented -> in_ready=0 and outputs unchanged; out_ready=1 -> held result consumed, new ADD accepted that cycle, its result valid the next cycle.
REQ-038 SHALL pass this abort case: flush at MUL cycle 10 -> IDLE, out_valid stays 0; rst at MUL cycle 5 -> all outputs 0 the next cycle.
